// File: rtl/xspi_axi_wdata_pp_buf.sv
// Two-entry ping-pong buffer for AXI W-channel beats feeding the XSPI write path.
// Occupancy is the FSM state; ready/valid are decoded from it alone.
//
//   state | meaning
//   EMPTY | no beat held, in_ready=1, out_valid=0
//   HALF  | one beat held, in_ready=1, out_valid=1
//   FULL  | two beats held, in_ready=0, out_valid=1
module xspi_axi_wdata_pp_buf #(
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = 4
) (
   input  logic                  axi_clk,
   input  logic                  axi_rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [STRB_WIDTH-1:0] in_strb,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [STRB_WIDTH-1:0] out_strb,
   output logic                  out_last,
   output logic                  rd_sel,
   output logic [1:0]            count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } occ_e;

   occ_e                  state_q, state_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] data_q [2];
   logic [STRB_WIDTH-1:0] strb_q [2];
   logic                  last_q [2];

   logic push, pop;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         state_q  <= EMPTY;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      case (state_q)
         EMPTY:   if (push) state_d = HALF;
         HALF: begin
            if (push && !pop)      state_d = FULL;
            else if (pop && !push) state_d = EMPTY;
         end
         FULL:    if (pop) state_d = HALF;
         default: state_d = EMPTY;
      endcase
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      // Abort wins over any handshake in the same cycle.
      if (flush) begin
         state_d  = EMPTY;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end
   end

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            strb_q[i] <= '0;
            last_q[i] <= 1'b0;
         end
      end else if (push && !flush) begin
         data_q[wr_ptr_q] <= in_data;
         strb_q[wr_ptr_q] <= in_strb;
         last_q[wr_ptr_q] <= in_last;
      end
   end

   assign out_data = data_q[rd_ptr_q];
   assign out_strb = strb_q[rd_ptr_q];
   assign out_last = last_q[rd_ptr_q];
   assign rd_sel   = rd_ptr_q;
   assign count    = state_q;

endmodule

// File: tb/tb_xspi_axi_wdata_pp_buf.sv
// Bench for the W-data ping-pong buffer: directed scenarios plus a randomized
// run checked against a queue model of a two-deep FIFO.
module tb_xspi_axi_wdata_pp_buf;

   logic        axi_clk = 1'b0;
   logic        axi_rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [3:0]  in_strb = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_strb;
   logic        out_last;
   logic        rd_sel;
   logic [1:0]  count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
      logic        l;
   } beat_t;

   xspi_axi_wdata_pp_buf #(.DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
      .axi_clk(axi_clk), .axi_rst(axi_rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_strb(in_strb), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_strb(out_strb),
      .out_last(out_last), .rd_sel(rd_sel), .count(count)
   );

   always #5 axi_clk = ~axi_clk;

   // Advance one clock edge and return at the following falling edge.
   task automatic step();
      @(posedge axi_clk);
      @(negedge axi_clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] s,
                        input logic l, input logic r, input logic f);
      in_valid = v; in_data = d; in_strb = s; in_last = l; out_ready = r; flush = f;
   endtask

   task automatic do_flush();
      drive(0, 32'h0, 4'h0, 0, 0, 1);
      step();
      drive(0, 32'h0, 4'h0, 0, 0, 0);
   endtask

   task automatic test_reset();
      @(negedge axi_clk);
      axi_rst = 1'b0;
      drive(1, 32'h1111_1111, 4'hF, 1, 0, 0); step();
      drive(1, 32'h2222_2222, 4'hE, 0, 0, 0); step();
      drive(0, 32'h0, 4'h0, 0, 1, 0);         step();
      drive(1, 32'h3333_3333, 4'hD, 1, 0, 0); step();
      drive(0, 32'h0, 4'h0, 0, 0, 0);
      checks++;
      if (count !== 2'd2 || rd_sel !== 1'b1) begin
         errors++; $display("FAIL reset_precond: count=%0d rd_sel=%0b, need 2/1", count, rd_sel);
      end
      #2 axi_rst = 1'b1;
      #1;
      checks++;
      if (count !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || rd_sel !== 1'b0 ||
          out_data !== 32'h0 || out_strb !== 4'h0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: count=%0d rdy=%0b vld=%0b sel=%0b data=%h strb=%h last=%0b, need 0/1/0/0/0/0/0",
                  count, in_ready, out_valid, rd_sel, out_data, out_strb, out_last);
      end
      @(negedge axi_clk);
      axi_rst = 1'b0;
      step();
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_release: count=%0d vld=%0b, need 0/0", count, out_valid);
      end
   endtask

   task automatic test_fill_drain();
      do_flush();
      drive(1, 32'hA0A0_A0A0, 4'hA, 0, 0, 0); step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA0A0_A0A0 || count !== 2'd1) begin
         errors++; $display("FAIL fill_latency: vld=%0b data=%h count=%0d, need 1/a0a0a0a0/1", out_valid, out_data, count);
      end
      drive(1, 32'hB1B1_B1B1, 4'hB, 1, 0, 0); step();
      drive(0, 32'h0, 4'h0, 0, 0, 0);
      checks++;
      if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA0A0_A0A0 || rd_sel !== 1'b0) begin
         errors++; $display("FAIL fill_full: count=%0d rdy=%0b data=%h sel=%0b, need 2/0/a0a0a0a0/0", count, in_ready, out_data, rd_sel);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hB1B1_B1B1 || out_last !== 1'b1 || rd_sel !== 1'b1 || in_ready !== 1'b1) begin
         errors++; $display("FAIL drain_second: vld=%0b data=%h last=%0b sel=%0b rdy=%0b, need 1/b1b1b1b1/1/1/1",
                            out_valid, out_data, out_last, rd_sel, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         errors++; $display("FAIL drain_empty: vld=%0b count=%0d, need 0/0", out_valid, count);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_streaming();
      do_flush();
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            checks++;
            if (count !== 2'd1 || out_valid !== 1'b1 || out_data !== 32'(i - 1) ||
                out_last !== (i - 1 == 7) || rd_sel !== 1'((i - 1) % 2)) begin
               errors++;
               $display("FAIL stream_beat%0d: count=%0d vld=%0b data=%0d last=%0b sel=%0b, need 1/1/%0d/%0b/%0d",
                        i - 1, count, out_valid, out_data, out_last, rd_sel, i - 1, (i - 1 == 7), (i - 1) % 2);
            end
         end
         if (i < 8) drive(1, 32'(i), 4'hF, (i == 7), 1, 0);
         else       drive(0, 32'h0, 4'h0, 0, 1, 0);
         step();
      end
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         errors++; $display("FAIL stream_end: vld=%0b count=%0d, need 0/0", out_valid, count);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      beat_t b0, b1;
      b0 = {$urandom, 4'($urandom), 1'b1};
      b1 = {$urandom, 4'($urandom), 1'b0};
      do_flush();
      drive(1, b0.d, b0.s, b0.l, 0, 0); step();
      drive(1, b1.d, b1.s, b1.l, 0, 0); step();
      drive(1, ~b0.d, ~b0.s, ~b0.l, 0, 0);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== b0.d || out_strb !== b0.s || out_last !== b0.l) begin
            errors++;
            $display("FAIL backpressure_c%0d: count=%0d rdy=%0b data=%h strb=%h last=%0b, need 2/0/%h/%h/%0b",
                     c, count, in_ready, out_data, out_strb, out_last, b0.d, b0.s, b0.l);
         end
         step();
      end
      drive(0, 32'h0, 4'h0, 0, 1, 0); step();
      checks++;
      if (out_data !== b1.d || out_strb !== b1.s || out_last !== b1.l || count !== 2'd1) begin
         errors++; $display("FAIL backpressure_next: data=%h count=%0d, need %h/1", out_data, count, b1.d);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL backpressure_drop: vld=%0b, need 0", out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      do_flush();
      drive(1, 32'h5555_0001, 4'h1, 0, 0, 0); step();
      drive(1, 32'hDEAD_BEEF, 4'h7, 1, 1, 1); step();
      drive(0, 32'h0, 4'h0, 0, 0, 0);
      checks++;
      if (count !== 2'd0 || rd_sel !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_clear: count=%0d sel=%0b vld=%0b rdy=%0b, need 0/0/0/1", count, rd_sel, out_valid, in_ready);
      end
      drive(1, 32'h5555_0002, 4'h2, 0, 0, 0); step();
      drive(0, 32'h0, 4'h0, 0, 1, 0);
      checks++;
      if (count !== 2'd1 || out_data !== 32'h5555_0002 || rd_sel !== 1'b0) begin
         errors++; $display("FAIL flush_dropped: count=%0d data=%h sel=%0b, need 1/55550002/0", count, out_data, rd_sel);
      end
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      do_flush();
      for (int k = 0; k < 3; k++) begin
         drive(1, 32'(k + 16), 4'hF, 0, 0, 0); step();
         drive(0, 32'h0, 4'h0, 0, 1, 0);       step();
      end
      drive(1, 32'hCC, 4'h3, 1, 0, 0); step();
      drive(0, 32'h0, 4'h0, 0, 0, 0);
      checks++;
      if (rd_sel !== 1'b1 || out_data !== 32'hCC || out_strb !== 4'h3 || count !== 2'd1) begin
         errors++; $display("FAIL wrap: sel=%0b data=%h strb=%h count=%0d, need 1/cc/3/1", rd_sel, out_data, out_strb, count);
      end
   endtask

   task automatic test_random();
      beat_t q[$];
      int    pops;
      logic  pu, po;
      beat_t b;
      do_flush();
      pops = 0;
      for (int c = 0; c < 400; c++) begin
         checks++;
         if (count !== 2'(q.size()) || in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0) ||
             rd_sel !== 1'(pops % 2) ||
             (q.size() > 0 && {out_data, out_strb, out_last} !== q[0])) begin
            errors++;
            $display("FAIL random_c%0d: count=%0d sel=%0b out=%h_%h_%0b, need %0d/%0d/%h", c, count, rd_sel,
                     out_data, out_strb, out_last, q.size(), pops % 2, (q.size() > 0) ? q[0] : beat_t'(0));
         end
         b = {$urandom, 4'($urandom), 1'($urandom)};
         drive(1'($urandom_range(0, 3) != 0), b.d, b.s, b.l, 1'($urandom_range(0, 2) == 0),
               ($urandom_range(0, 24) == 0));
         if (flush) begin
            q.delete();
            pops = 0;
         end else begin
            pu = in_valid && (q.size() < 2);
            po = out_ready && (q.size() > 0);
            if (po) begin
               void'(q.pop_front());
               pops++;
            end
            if (pu) q.push_back(b);
         end
         step();
      end
      drive(0, 32'h0, 4'h0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_streaming();
      test_backpressure();
      test_flush();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xspi_axi_wdata_pp_buf.md
# xspi_axi_wdata_pp_buf

Two-entry ping-pong buffer for AXI write-data beats in the XSPI AXI slave. It accepts beats from the AXI W channel with a valid/ready handshake and holds them in two alternating registers. It presents the oldest beat to the downstream XSPI write path. Its read pointer `rd_sel` drives the select of the 2-input output mux that picks between entry 0 and entry 1, so entry storage, pointers and mux select stay consistent by construction.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: width of one write-data beat.
- `STRB_WIDTH`, default 4: byte-strobe width; the block does not check it against `DATA_WIDTH/8`.

Ports:
- `axi_clk`, input, 1: the block's only clock; all state updates on the rising edge.
- `axi_rst`, input, 1: reset, asynchronous and active-high; clears all state.
- `flush`, input, 1: synchronous clear of buffer contents, for transaction abort.
- `in_valid`, input, 1: upstream beat valid.
- `in_ready`, output, 1: buffer can accept a beat.
- `in_data`, input, `DATA_WIDTH`: upstream write data.
- `in_strb`, input, `STRB_WIDTH`: upstream byte strobes.
- `in_last`, input, 1: last beat of the burst.
- `out_valid`, output, 1: a beat is available.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_data`, output, `DATA_WIDTH`: oldest buffered data.
- `out_strb`, output, `STRB_WIDTH`: oldest buffered strobes.
- `out_last`, output, 1: oldest buffered last flag.
- `rd_sel`, output, 1: read pointer; it is the output mux select (0 = entry 0, 1 = entry 1).
- `count`, output, 2: occupancy, 0 to 2.

## Operation
- Storage: two entries, each holding {data, strb, last}. Internal registers are `wr_ptr` (1 bit) and `rd_ptr` (1 bit, driven out as `rd_sel`).
- Occupancy states, held in `count`:
  - EMPTY (0): `in_ready`=1, `out_valid`=0.
  - HALF (1): `in_ready`=1, `out_valid`=1.
  - FULL (2): `in_ready`=0, `out_valid`=1.
- `in_ready` and `out_valid` are decoded from registered `count` only. There is no combinational path from `out_ready` to `in_ready` or from `in_valid` to `out_valid`.
- Push (`in_valid && in_ready`):
  - Write {`in_data`, `in_strb`, `in_last`} to entry[`wr_ptr`].
  - Toggle `wr_ptr`.
- Pop (`out_valid && out_ready`):
  - Toggle `rd_ptr`.
  - Entry contents are not cleared.
- Count update:
  - Push only: `count`+1.
  - Pop only: `count`−1.
  - Push and pop in the same cycle (legal only in HALF): `count` unchanged, both pointers toggle.
- Output path: `out_data`, `out_strb` and `out_last` equal entry[`rd_ptr`], selected combinationally from registered entries. They are stable while `out_valid`=1 and `out_ready`=0.
- Push while FULL cannot occur because `in_ready`=0. Pop while EMPTY cannot occur because `out_valid`=0.
- Pointer wrap: the 1-bit pointers wrap naturally, 1 to 0.
- `flush`=1:
  - Next edge: `count`=0, `wr_ptr`=0, `rd_ptr`=0.
  - Any push or pop in the same cycle is ignored.
  - Entry contents are retained but unused.
- `last` is stored and forwarded only. No burst tracking is done inside this block.

## Timing
- Reset values, asserted asynchronously:
  - `count`=0, `wr_ptr`=0, `rd_ptr`=0, all entries=0.
  - Resulting outputs: `in_ready`=1, `out_valid`=0, `rd_sel`=0, `out_data`=0, `out_strb`=0, `out_last`=0.
- Reset asserted mid-burst: all state cleared immediately and buffered beats are lost. The first edge after deassertion behaves as EMPTY.
- Latency: a beat pushed at edge N appears on the outputs with `out_valid`=1 after edge N (visible in cycle N+1). There is no same-cycle pass-through.
- Throughput: one beat per cycle sustained in HALF with continuous push and pop.
- Recovery from FULL: a pop at edge N gives `in_ready`=1 in cycle N+1, so the producer sees one bubble.
- `rd_sel` changes only on a pop edge, a flush edge or reset.

## Test plan
- Reset: assert `axi_rst` with `count`=2 → `count`=0, `in_ready`=1, `out_valid`=0, `rd_sel`=0, `out_data`=0 immediately, without waiting for a clock edge.
- Fill and drain: push 0xA0A0A0A0 then 0xB1B1B1B1 with `out_ready`=0 → `count`=2, `in_ready`=0, `out_data`=0xA0A0A0A0, `rd_sel`=0. Then raise `out_ready` → outputs 0xA0A0A0A0, then 0xB1B1B1B1 with `rd_sel`=1, then `out_valid`=0.
- Streaming: 8 beats 0..7 with `in_valid` and `out_ready` held at 1 → `count` stays at 1 after the first beat, output order is 0..7, `rd_sel` alternates 0,1,0,1…, and `in_last` on beat 7 appears as `out_last` only on beat 7.
- Backpressure stability: hold `out_ready`=0 for 5 cycles while FULL → `out_data`, `out_strb` and `out_last` do not change, and `in_valid` held at 1 is not accepted.
- Flush: in HALF, assert `flush` together with `in_valid` and `out_ready` → next cycle `count`=0, `rd_sel`=0, `out_valid`=0, and the beat offered in the flush cycle is dropped.
- Pointer wrap: 3 push/pop pairs, then push 0xCC with `out_ready`=0 → `rd_sel`=1 and `out_data`=0xCC, read from entry 1.
